// File: rtl/sa_xaddr_channel_pkg.sv
// Shared definitions for the slave-side address arbiter and the response dispatcher.
// The slave-port ID is always {mst_idx, mst_id}: the master index sits in the MSBs.
package sa_xaddr_channel_pkg;

    localparam int unsigned DEF_MST_AMT         = 2;
    localparam int unsigned DEF_OUTSTANDING_AMT = 8;
    localparam int unsigned DEF_TRANS_MST_ID_W  = 5;

    // Width of a master index; a single master still needs one bit to carry it.
    function automatic int unsigned mstIdWidth(input int unsigned mstAmt);
        return (mstAmt > 1) ? $clog2(mstAmt) : 1;
    endfunction

    function automatic int unsigned slvIdWidth(input int unsigned transMstIdW,
                                               input int unsigned mstAmt);
        return transMstIdW + mstIdWidth(mstAmt);
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO; head is visible combinationally, push/pop ignored when full/empty.
module fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             ACLK_i,
    input  logic             ARESETn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtrQ, rdPtrQ;
    logic [CNT_W-1:0] cntQ;
    logic             doPush, doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cntQ == '0);
    assign full_o  = (cntQ == CNT_W'(DEPTH));
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign head_o  = mem[rdPtrQ];

    always_ff @(posedge ACLK_i) begin
        if (doPush) begin
            mem[wrPtrQ] <= pushData_i;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            cntQ   <= '0;
        end else begin
            if (doPush) wrPtrQ <= nextPtr(wrPtrQ);
            if (doPop)  rdPtrQ <= nextPtr(rdPtrQ);
            unique case ({doPush, doPop})
                2'b10:   cntQ <= cntQ + 1'b1;
                2'b01:   cntQ <= cntQ - 1'b1;
                default: cntQ <= cntQ;
            endcase
        end
    end

endmodule

// File: rtl/sa_xaddr_channel_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps; grant gated by en.
module sa_xaddr_channel_rr_arbiter #(
    parameter int unsigned REQ_AMT = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [REQ_AMT-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [REQ_AMT-1:0] gnt_o,
    output logic [IDX_W-1:0]   gntIdx_o
);

    logic             found;
    logic [IDX_W-1:0] candIdx;

    always_comb begin
        gnt_o    = '0;
        gntIdx_o = '0;
        found    = 1'b0;
        candIdx  = '0;
        for (int unsigned off = 0; off < REQ_AMT; off++) begin
            candIdx = IDX_W'((32'(ptr_i) + off) % REQ_AMT);
            if (!found && req_i[candIdx]) begin
                found    = 1'b1;
                gntIdx_o = candIdx;
            end
        end
        if (en_i && found) begin
            gnt_o[gntIdx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sa_xaddr_channel.sv
// Slave-side address channel: round-robin over master dispatchers into a one-deep stage,
// with an order FIFO telling the xDATA arbiter which master owns the current burst.
module sa_xaddr_channel
    import sa_xaddr_channel_pkg::*;
#(
    parameter int unsigned MST_AMT           = DEF_MST_AMT,
    parameter int unsigned OUTSTANDING_AMT   = DEF_OUTSTANDING_AMT,
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned TRANS_MST_ID_W    = DEF_TRANS_MST_ID_W,
    parameter int unsigned TRANS_BURST_W     = 2,
    parameter int unsigned TRANS_DATA_LEN_W  = 3,
    parameter int unsigned TRANS_DATA_SIZE_W = 3,
    parameter int unsigned MST_ID_W          = mstIdWidth(MST_AMT),
    parameter int unsigned TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESETn_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AxID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AxADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_AxBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AxLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_AxSIZE_i,
    input  logic [MST_AMT-1:0]                    dsp_AxVALID_i,
    input  logic [MST_AMT-1:0]                    dsp_Ax_outst_full_i,
    output logic [MST_AMT-1:0]                    dsp_AxREADY_o,
    output logic [TRANS_SLV_ID_W-1:0]             s_AxID_o,
    output logic [ADDR_WIDTH-1:0]                 s_AxADDR_o,
    output logic [TRANS_BURST_W-1:0]              s_AxBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]           s_AxLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]          s_AxSIZE_o,
    output logic                                  s_AxVALID_o,
    input  logic                                  s_AxREADY_i,
    input  logic                                  s_xVALID_i,
    input  logic                                  s_xREADY_i,
    output logic [MST_ID_W-1:0]                   sa_xDATA_mst_id_o,
    output logic                                  sa_xDATA_disable_o
);

    localparam int unsigned ORD_W = MST_ID_W + TRANS_DATA_LEN_W;

    logic [MST_AMT-1:0]           req;
    logic [MST_AMT-1:0]           gnt;
    logic [MST_ID_W-1:0]          gntIdx;
    logic [MST_ID_W-1:0]          rrPtrQ, rrPtrD;
    logic                         stageFree, gntEn;
    logic                         fifoFull, fifoEmpty;
    logic [ORD_W-1:0]             fifoHead;
    logic [TRANS_DATA_LEN_W-1:0]  headLen;
    logic [TRANS_DATA_LEN_W-1:0]  beatCntQ;
    logic                         beat, last;

    logic [TRANS_MST_ID_W-1:0]    selId;
    logic [ADDR_WIDTH-1:0]        selAddr;
    logic [TRANS_BURST_W-1:0]     selBurst;
    logic [TRANS_DATA_LEN_W-1:0]  selLen;
    logic [TRANS_DATA_SIZE_W-1:0] selSize;

    assign req       = dsp_AxVALID_i & ~dsp_Ax_outst_full_i;
    assign stageFree = ~s_AxVALID_o | s_AxREADY_i;
    // A full order FIFO blocks grants even if it pops this cycle; reset also forces ready low.
    assign gntEn     = ARESETn_i & stageFree & ~fifoFull & (|req);
    assign dsp_AxREADY_o = gnt;

    sa_xaddr_channel_rr_arbiter #(
        .REQ_AMT (MST_AMT),
        .IDX_W   (MST_ID_W)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (rrPtrQ),
        .en_i     (gntEn),
        .gnt_o    (gnt),
        .gntIdx_o (gntIdx)
    );

    always_comb begin
        selId    = '0;
        selAddr  = '0;
        selBurst = '0;
        selLen   = '0;
        selSize  = '0;
        for (int unsigned m = 0; m < MST_AMT; m++) begin
            if (MST_ID_W'(m) == gntIdx) begin
                selId    = dsp_AxID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                selAddr  = dsp_AxADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                selBurst = dsp_AxBURST_i[m*TRANS_BURST_W +: TRANS_BURST_W];
                selLen   = dsp_AxLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                selSize  = dsp_AxSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            end
        end
    end

    assign rrPtrD = (gntIdx == MST_ID_W'(MST_AMT - 1)) ? '0 : gntIdx + 1'b1;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            s_AxVALID_o <= 1'b0;
            s_AxID_o    <= '0;
            s_AxADDR_o  <= '0;
            s_AxBURST_o <= '0;
            s_AxLEN_o   <= '0;
            s_AxSIZE_o  <= '0;
            rrPtrQ      <= '0;
        end else if (gntEn) begin
            s_AxVALID_o <= 1'b1;
            s_AxID_o    <= {gntIdx, selId};
            s_AxADDR_o  <= selAddr;
            s_AxBURST_o <= selBurst;
            s_AxLEN_o   <= selLen;
            s_AxSIZE_o  <= selSize;
            rrPtrQ      <= rrPtrD;
        end else if (s_AxREADY_i) begin
            s_AxVALID_o <= 1'b0;
        end
    end

    fifo #(
        .WIDTH (ORD_W),
        .DEPTH (OUTSTANDING_AMT)
    ) u_order_fifo (
        .ACLK_i     (ACLK_i),
        .ARESETn_i  (ARESETn_i),
        .push_i     (gntEn),
        .pushData_i ({gntIdx, selLen}),
        .pop_i      (last),
        .head_o     (fifoHead),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull)
    );

    assign headLen = fifoHead[TRANS_DATA_LEN_W-1:0];
    assign beat    = s_xVALID_i & s_xREADY_i;
    assign last    = beat & ~fifoEmpty & (beatCntQ == headLen);

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            beatCntQ <= '0;
        end else if (last) begin
            beatCntQ <= '0;
        end else if (beat && !fifoEmpty) begin
            beatCntQ <= beatCntQ + 1'b1;
        end
    end

    // Head storage is uninitialised after reset, so the index is forced to 0 while empty.
    assign sa_xDATA_mst_id_o  = fifoEmpty ? '0 : fifoHead[ORD_W-1 -: MST_ID_W];
    assign sa_xDATA_disable_o = fifoEmpty;

`ifndef SYNTHESIS
    beatWithoutOwner: assert property (@(posedge ACLK_i) disable iff (!ARESETn_i)
                                       !(beat && fifoEmpty))
        else $error("data beat while order fifo is empty");
`endif

endmodule

// File: tb/tb_sa_xaddr_channel.sv
// Bench for sa_xaddr_channel: queue-based reference model checked every cycle plus directed pins.
module tb_sa_xaddr_channel;

    localparam int MST = 2;
    localparam int OUT = 8;

    logic        ACLK_i;
    logic        ARESETn_i;
    logic [4:0]  idA    [MST];
    logic [31:0] addrA  [MST];
    logic [1:0]  burstA [MST];
    logic [2:0]  lenA   [MST];
    logic [2:0]  sizeA  [MST];
    logic [1:0]  dsp_AxVALID_i, dsp_Ax_outst_full_i, dsp_AxREADY_o;
    logic [9:0]  dsp_AxID_i;
    logic [63:0] dsp_AxADDR_i;
    logic [3:0]  dsp_AxBURST_i;
    logic [5:0]  dsp_AxLEN_i, dsp_AxSIZE_i;
    logic [5:0]  s_AxID_o;
    logic [31:0] s_AxADDR_o;
    logic [1:0]  s_AxBURST_o;
    logic [2:0]  s_AxLEN_o, s_AxSIZE_o;
    logic        s_AxVALID_o, s_AxREADY_i, s_xVALID_i, s_xREADY_i;
    logic        sa_xDATA_mst_id_o, sa_xDATA_disable_o;

    assign dsp_AxID_i    = {idA[1], idA[0]};
    assign dsp_AxADDR_i  = {addrA[1], addrA[0]};
    assign dsp_AxBURST_i = {burstA[1], burstA[0]};
    assign dsp_AxLEN_i   = {lenA[1], lenA[0]};
    assign dsp_AxSIZE_i  = {sizeA[1], sizeA[0]};

    sa_xaddr_channel dut (
        .ACLK_i              (ACLK_i),
        .ARESETn_i           (ARESETn_i),
        .dsp_AxID_i          (dsp_AxID_i),
        .dsp_AxADDR_i        (dsp_AxADDR_i),
        .dsp_AxBURST_i       (dsp_AxBURST_i),
        .dsp_AxLEN_i         (dsp_AxLEN_i),
        .dsp_AxSIZE_i        (dsp_AxSIZE_i),
        .dsp_AxVALID_i       (dsp_AxVALID_i),
        .dsp_Ax_outst_full_i (dsp_Ax_outst_full_i),
        .dsp_AxREADY_o       (dsp_AxREADY_o),
        .s_AxID_o            (s_AxID_o),
        .s_AxADDR_o          (s_AxADDR_o),
        .s_AxBURST_o         (s_AxBURST_o),
        .s_AxLEN_o           (s_AxLEN_o),
        .s_AxSIZE_o          (s_AxSIZE_o),
        .s_AxVALID_o         (s_AxVALID_o),
        .s_AxREADY_i         (s_AxREADY_i),
        .s_xVALID_i          (s_xVALID_i),
        .s_xREADY_i          (s_xREADY_i),
        .sa_xDATA_mst_id_o   (sa_xDATA_mst_id_o),
        .sa_xDATA_disable_o  (sa_xDATA_disable_o)
    );

    initial ACLK_i = 1'b0;
    always #5 ACLK_i = ~ACLK_i;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one-entry stage, rotating priority, and a queue of {master, len}.
    typedef struct {int mst; int len;} ent_t;
    ent_t mq[$];
    int   mdlPtr, mdlBeats, mdlValid;
    int   mdlId, mdlAddr, mdlBurst, mdlLen, mdlSize;

    function automatic int mdlGrant();
        if (!ARESETn_i) return -1;
        if (mdlValid != 0 && !s_AxREADY_i) return -1;
        if (mq.size() >= OUT) return -1;
        for (int k = 0; k < MST; k++) begin
            int m = (mdlPtr + k) % MST;
            if (dsp_AxVALID_i[m] && !dsp_Ax_outst_full_i[m]) return m;
        end
        return -1;
    endfunction

    always @(posedge ACLK_i or negedge ARESETn_i) begin : model
        int g;
        bit bt, pop;
        if (!ARESETn_i) begin
            mdlValid <= 0;
            mdlPtr   <= 0;
            mdlBeats <= 0;
            mq.delete();
        end else begin
            g   = mdlGrant();
            bt  = s_xVALID_i && s_xREADY_i && mq.size() > 0;
            pop = bt && (mdlBeats == mq[0].len);
            if (pop) mdlBeats <= 0;
            else if (bt) mdlBeats <= mdlBeats + 1;
            if (g >= 0) begin
                mdlValid <= 1;
                mdlId    <= g * 32 + int'(idA[g]);
                mdlAddr  <= int'(addrA[g]);
                mdlBurst <= int'(burstA[g]);
                mdlLen   <= int'(lenA[g]);
                mdlSize  <= int'(sizeA[g]);
                mdlPtr   <= (g + 1) % MST;
            end else if (s_AxREADY_i) begin
                mdlValid <= 0;
            end
            if (pop) void'(mq.pop_front());
            if (g >= 0) mq.push_back('{mst: g, len: int'(lenA[g])});
        end
    end

    always @(negedge ACLK_i) begin : cmp
        int g;
        g = mdlGrant();
        chk("cmp_ready", 64'(dsp_AxREADY_o), (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("cmp_svalid", 64'(s_AxVALID_o), 64'(mdlValid));
        if (mdlValid != 0) begin
            chk("cmp_id",    64'(s_AxID_o),    64'(mdlId));
            chk("cmp_addr",  64'(s_AxADDR_o),  64'(unsigned'(mdlAddr)));
            chk("cmp_burst", 64'(s_AxBURST_o), 64'(mdlBurst));
            chk("cmp_len",   64'(s_AxLEN_o),   64'(mdlLen));
            chk("cmp_size",  64'(s_AxSIZE_o),  64'(mdlSize));
        end
        chk("cmp_disable", 64'(sa_xDATA_disable_o), 64'(mq.size() == 0));
        if (mq.size() != 0) chk("cmp_mstid", 64'(sa_xDATA_mst_id_o), 64'(mq[0].mst));
    end

    task automatic cyc();
        @(posedge ACLK_i);
        #1;
    endtask

    initial begin
        ARESETn_i = 1'b0;
        idA[0] = 5'd3;  addrA[0] = 32'h1000_0000; burstA[0] = 2'd1; lenA[0] = 3'd0; sizeA[0] = 3'd2;
        idA[1] = 5'd5;  addrA[1] = 32'h4000_0010; burstA[1] = 2'd2; lenA[1] = 3'd0; sizeA[1] = 3'd3;
        dsp_AxVALID_i = 2'b00; dsp_Ax_outst_full_i = 2'b00;
        s_AxREADY_i = 1'b1; s_xVALID_i = 1'b0; s_xREADY_i = 1'b1;
        repeat (2) @(posedge ACLK_i);
        #1;
        chk("rst_svalid",  64'(s_AxVALID_o), 64'd0);
        chk("rst_disable", 64'(sa_xDATA_disable_o), 64'd1);
        chk("rst_mstid",   64'(sa_xDATA_mst_id_o), 64'd0);
        chk("rst_addr",    64'(s_AxADDR_o), 64'd0);
        ARESETn_i = 1'b1;

        // Both masters every cycle, LEN=0: grants alternate 0,1,0,...
        dsp_AxVALID_i = 2'b11;
        #1 chk("alt_rdy0", 64'(dsp_AxREADY_o), 64'd1);
        cyc(); #1;
        chk("alt_rdy1", 64'(dsp_AxREADY_o), 64'd2);
        chk("alt_msb0", 64'(s_AxID_o[5]), 64'd0);
        chk("alt_val",  64'(s_AxVALID_o), 64'd1);
        cyc(); #1;
        chk("alt_msb1", 64'(s_AxID_o[5]), 64'd1);
        chk("alt_rdy2", 64'(dsp_AxREADY_o), 64'd1);
        repeat (4) cyc();
        dsp_AxVALID_i = 2'b00; s_xVALID_i = 1'b1;
        repeat (6) cyc();
        s_xVALID_i = 1'b0;
        #1 chk("alt_drained", 64'(sa_xDATA_disable_o), 64'd1);

        // Master 1 alone, LEN=3: four beats retire it.
        lenA[1] = 3'd3; dsp_AxVALID_i = 2'b10;
        #1 chk("m1_rdy", 64'(dsp_AxREADY_o), 64'd2);
        cyc();
        dsp_AxVALID_i = 2'b00; s_xVALID_i = 1'b1;
        #1;
        chk("m1_val",  64'(s_AxVALID_o), 64'd1);
        chk("m1_id",   64'(s_AxID_o), 64'h25);
        chk("m1_addr", 64'(s_AxADDR_o), 64'h4000_0010);
        chk("m1_dis0", 64'(sa_xDATA_disable_o), 64'd0);
        repeat (3) cyc();
        #1 chk("m1_dis3beats", 64'(sa_xDATA_disable_o), 64'd0);
        cyc();
        s_xVALID_i = 1'b0;
        #1 chk("m1_dis4beats", 64'(sa_xDATA_disable_o), 64'd1);

        // Slave stalls: first request held in the stage, no second grant.
        s_AxREADY_i = 1'b0; dsp_AxVALID_i = 2'b01;
        #1 chk("stall_rdy0", 64'(dsp_AxREADY_o), 64'd1);
        cyc();
        #1 chk("stall_rdy1", 64'(dsp_AxREADY_o), 64'd0);
        repeat (4) cyc();
        #1;
        chk("stall_rdy5", 64'(dsp_AxREADY_o), 64'd0);
        chk("stall_addr", 64'(s_AxADDR_o), 64'h1000_0000);
        chk("stall_val",  64'(s_AxVALID_o), 64'd1);
        dsp_AxVALID_i = 2'b00; s_AxREADY_i = 1'b1;
        cyc();
        s_xVALID_i = 1'b1;
        cyc();
        s_xVALID_i = 1'b0;
        #1 chk("stall_onepush", 64'(sa_xDATA_disable_o), 64'd1);

        // Order FIFO fills at 8 entries; one completed burst re-opens grants.
        lenA[0] = 3'd1; dsp_AxVALID_i = 2'b01;
        repeat (8) cyc();
        #1 chk("full_rdy", 64'(dsp_AxREADY_o), 64'd0);
        s_xVALID_i = 1'b1;
        cyc();
        #1 chk("full_rdy_beat", 64'(dsp_AxREADY_o), 64'd0);
        cyc();
        s_xVALID_i = 1'b0;
        #1 chk("full_resume", 64'(dsp_AxREADY_o), 64'd1);
        cyc();
        dsp_AxVALID_i = 2'b00; s_xVALID_i = 1'b1;
        repeat (16) cyc();
        s_xVALID_i = 1'b0;
        #1 chk("full_drained", 64'(sa_xDATA_disable_o), 64'd1);

        // Master 0 blocked by its own outstanding-full flag.
        lenA[0] = 3'd0; lenA[1] = 3'd0;
        dsp_Ax_outst_full_i = 2'b01; dsp_AxVALID_i = 2'b11;
        #1 chk("ofull_rdy0", 64'(dsp_AxREADY_o), 64'd2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1 chk("ofull_rdy", 64'(dsp_AxREADY_o), 64'd2);
        end
        dsp_AxVALID_i = 2'b00; dsp_Ax_outst_full_i = 2'b00;
        #1 chk("ofull_head", 64'(sa_xDATA_mst_id_o), 64'd1);
        s_xVALID_i = 1'b1;
        repeat (3) cyc();
        s_xVALID_i = 1'b0;

        // Reset in the middle of a burst with a held stage and three queued entries.
        lenA[0] = 3'd3; lenA[1] = 3'd3; dsp_AxVALID_i = 2'b11;
        repeat (3) cyc();
        dsp_AxVALID_i = 2'b00; s_AxREADY_i = 1'b0; s_xVALID_i = 1'b1;
        repeat (2) cyc();
        s_xVALID_i = 1'b0;
        #1;
        chk("mid_val",  64'(s_AxVALID_o), 64'd1);
        chk("mid_dis",  64'(sa_xDATA_disable_o), 64'd0);
        dsp_AxVALID_i = 2'b11; s_AxREADY_i = 1'b1;
        ARESETn_i = 1'b0;
        #1;
        chk("arst_val",  64'(s_AxVALID_o), 64'd0);
        chk("arst_dis",  64'(sa_xDATA_disable_o), 64'd1);
        chk("arst_rdy",  64'(dsp_AxREADY_o), 64'd0);
        chk("arst_mst",  64'(sa_xDATA_mst_id_o), 64'd0);
        repeat (2) cyc();
        ARESETn_i = 1'b1;
        #1 chk("post_rst_tie", 64'(dsp_AxREADY_o), 64'd1);
        cyc();
        dsp_AxVALID_i = 2'b00;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
